// File: rtl/cnn_accel_pkg.sv
//==============================================================================
// Module   : cnn_accel_pkg
// Brief    : Shared constants, packer state encoding and clog2 helper.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package cnn_accel_pkg;

    localparam int ELEM_W_DEFAULT = 5;

    localparam logic [1:0] PACK_IDLE = 2'd0;
    localparam logic [1:0] PACK_FILL = 2'd1;
    localparam logic [1:0] PACK_HOLD = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vector_fwft_fifo.sv
//==============================================================================
// Module   : vector_fwft_fifo
// Brief    : First-word-fall-through FIFO holding completed packer vectors.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vector_fwft_fifo
    import cnn_accel_pkg::*;
#(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4,
    parameter int CNT_W = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;

    assign w_flush = rst | clear;
    assign w_push  = push & ~full;
    assign w_pop   = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Storage is not reset; empty masks stale entries on the read port.
    always_ff @(posedge clk) begin
        if (w_push && !w_flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign cnt      = r_cnt;
    assign full     = (r_cnt == CNT_W'(DEPTH));
    assign empty    = (r_cnt == '0);
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/ifmaps_vector_packer.sv
//==============================================================================
// Module   : ifmaps_vector_packer
// Brief    : Packs AXIS activation bytes into LANES-wide ELEM_W vectors with
//            per-row zero padding; optional PACKER_TLAST_FLUSH_EN ends rows on TLAST.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ifmaps_vector_packer
    import cnn_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ELEM_W = ELEM_W_DEFAULT,
    parameter int LANES  = 256,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       S_AXIS_TDATA,
    input  logic                    S_AXIS_TVALID,
    input  logic                    S_AXIS_TLAST,
    output logic                    S_AXIS_TREADY,
    input  logic                    axis_en,
    input  logic                    axis_clear,
    input  logic [11:0]             input_channel_size,
    output logic [LANES*ELEM_W-1:0] o_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    o_last,
    output logic [CNT_W-1:0]        fifo_cnt,
    output logic                    fifo_full,
    output logic                    fifo_empty
);

    localparam int BE    = DATA_W / 8;
    localparam int LI_W  = clog2(LANES) + 1;
    localparam int VEC_W = LANES * ELEM_W;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [LI_W-1:0]   r_lane_idx;
    logic [11:0]       r_ch_cnt;
    logic [VEC_W-1:0]  r_pack;
    logic [VEC_W-1:0]  w_vec;
    logic              w_accept;
    logic              w_ch_end;
    logic              w_row_end;
    logic              w_full_vec;
    logic              w_push;
    logic [11:0]       w_take;
    logic [VEC_W:0]    w_fifo_data;
    logic [DATA_W-1:0] w_unused_tdata;

    assign w_unused_tdata = S_AXIS_TDATA;

    assign S_AXIS_TREADY = axis_en & ~fifo_full & ~axis_clear & (r_state != PACK_IDLE);
    assign w_accept      = S_AXIS_TVALID & S_AXIS_TREADY;

    assign w_ch_end   = (input_channel_size != 12'd0) &&
                        (({1'b0, r_ch_cnt} + 13'(BE)) >= {1'b0, input_channel_size});
    assign w_full_vec = (r_lane_idx == LI_W'(LANES - BE));
    assign w_take     = w_ch_end ? (input_channel_size - r_ch_cnt) : 12'(BE);

`ifdef PACKER_TLAST_FLUSH_EN
    assign w_row_end = w_ch_end | S_AXIS_TLAST;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = S_AXIS_TLAST;
    assign w_row_end      = w_ch_end;
`endif

    assign w_push = w_accept & (w_row_end | w_full_vec);

    // Elements beyond the row boundary are dropped; untouched lanes keep the
    // zero left by the previous push.
    always_comb begin
        w_vec = r_pack;
        for (int k = 0; k < BE; k++) begin
            if (12'(k) < w_take)
                w_vec[(int'(r_lane_idx) + k)*ELEM_W +: ELEM_W] = S_AXIS_TDATA[8*k +: ELEM_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || axis_clear) begin
            r_lane_idx <= '0;
            r_ch_cnt   <= '0;
            r_pack     <= '0;
        end else if (w_accept) begin
            if (w_push) begin
                r_pack     <= '0;
                r_lane_idx <= '0;
                r_ch_cnt   <= w_row_end ? 12'd0 : r_ch_cnt + 12'(BE);
            end else begin
                r_pack     <= w_vec;
                r_lane_idx <= r_lane_idx + LI_W'(BE);
                r_ch_cnt   <= r_ch_cnt + 12'(BE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || axis_clear) r_state <= PACK_IDLE;
        else                   r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PACK_IDLE: if (axis_en) w_state_next = PACK_FILL;
            PACK_FILL: begin
                if (!axis_en)       w_state_next = PACK_IDLE;
                else if (fifo_full) w_state_next = PACK_HOLD;
            end
            PACK_HOLD: if (fifo_cnt < CNT_W'(DEPTH)) w_state_next = PACK_FILL;
            default:   w_state_next = PACK_IDLE;
        endcase
    end

    vector_fwft_fifo #(
        .WIDTH (VEC_W + 1),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (axis_clear),
        .push      (w_push),
        .push_data ({w_row_end, w_vec}),
        .pop       (o_valid & o_ready),
        .pop_data  (w_fifo_data),
        .cnt       (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_valid = ~fifo_empty;
    assign o_last  = w_fifo_data[VEC_W];
    assign o_data  = w_fifo_data[VEC_W-1:0];

endmodule

`default_nettype wire

// File: doc/ifmaps_vector_packer.md
# ifmaps_vector_packer

Parametrised successor to the ifmaps preload stage. It accepts AXI-Stream beats of packed 8-bit activations and truncates each byte to an `ELEM_W`-bit element. Elements are packed into `LANES`-wide vectors, and each vector row is terminated at the configured input-channel count with zero padding. Completed vectors are buffered in a `DEPTH`-entry first-word-fall-through FIFO that feeds the MAC array control and BRAM weight path.

## Interface
- `DATA_W`, 32: AXIS TDATA width; multiple of 8.
- `ELEM_W`, 5: output element width; ≤ 8.
- `LANES`, 256: elements per output vector; must be a multiple of `DATA_W/8`.
- `DEPTH`, 4: vector FIFO entries; power of two, ≥ 2.
- `CNT_W`, `clog2(DEPTH)+1`: occupancy counter width.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `S_AXIS_TDATA`, in, `DATA_W`: byte 0 is bits [7:0].
- `S_AXIS_TVALID`, in, 1.
- `S_AXIS_TLAST`, in, 1.
- `S_AXIS_TREADY`, out, 1.
- `axis_en`, in, 1: accept enable.
- `axis_clear`, in, 1: synchronous flush of all state.
- `input_channel_size`, in, 12: elements per row; 0 = no row termination.
- `o_data`, out, `LANES*ELEM_W`: lane i = bits [i*ELEM_W +: ELEM_W].
- `o_valid`, out, 1.
- `o_ready`, in, 1.
- `o_last`, out, 1: head vector ends a row.
- `fifo_cnt`, out, `CNT_W`.
- `fifo_full`, out, 1.
- `fifo_empty`, out, 1.

## Operation
- Definitions: `BE = DATA_W/8` elements per beat; `BPV = LANES/BE` beats per full vector.
- Element k of a beat is `TDATA[8k +: ELEM_W]`; the upper bits of each byte are discarded.
- A beat is accepted when `S_AXIS_TVALID & S_AXIS_TREADY`. Accepted elements go to the pack register at lane `lane_idx`, in order.
- Counters:
  - `lane_idx` ranges 0..LANES-BE, in steps of BE.
  - `ch_cnt` counts elements consumed in the current row, 12 bits.
- Vector completion (evaluated on each accepted beat):
  - Row end: `input_channel_size != 0` and `ch_cnt + BE >= input_channel_size`.
    - Only `input_channel_size - ch_cnt` elements of the beat are taken; the rest are dropped.
    - Unfilled lanes are zero.
    - Set `o_last` = 1, `ch_cnt` = 0, `lane_idx` = 0.
  - Full vector: `lane_idx == LANES-BE` and not a row end.
    - Push with `o_last` = 0, set `lane_idx` = 0, and `ch_cnt` += BE.
  - Otherwise `lane_idx` += BE and `ch_cnt` += BE.
- The pack register is cleared to zero after every push.
- State machine:
  - `IDLE`: `axis_en` = 0, or just cleared. Moves to `FILL` when `axis_en` = 1.
  - `FILL`: accepting beats. Moves to `HOLD` when the FIFO becomes full. Moves to `IDLE` when `axis_en` falls; the partial vector is kept.
  - `HOLD`: `TREADY` = 0. Moves to `FILL` when `fifo_cnt < DEPTH`.
- `S_AXIS_TREADY = axis_en & ~fifo_full & ~axis_clear & (state != IDLE)`.
  - This is conservative: ready drops when the FIFO is full even if the next beat would not complete a vector.
- FIFO:
  - Pop on `o_valid & o_ready`.
  - Simultaneous push and pop leaves `fifo_cnt` unchanged.
  - Pointers wrap modulo `DEPTH`.
- `axis_clear` and `rst` have identical effect:
  - pointers, `fifo_cnt`, `lane_idx` and `ch_cnt` are set to 0;
  - the pack register is set to 0;
  - state goes to `IDLE`.
  - Any beat or pop presented in that cycle is ignored.
- Reset values:
  - `S_AXIS_TREADY` = 0
  - `o_valid` = 0
  - `o_last` = 0
  - `o_data` = 0
  - `fifo_cnt` = 0
  - `fifo_full` = 0
  - `fifo_empty` = 1

## Timing
- A vector completed by a beat accepted at edge N is visible (`o_valid` = 1) in cycle N+1 when the FIFO was empty. The FIFO is first-word-fall-through.
- `fifo_full` and `S_AXIS_TREADY` are updated from the registered `fifo_cnt`. A pop at edge N re-enables ready in cycle N+1.
- `o_data` and `o_last` are stable while `o_valid & ~o_ready`.
- `input_channel_size` is sampled every beat and must only change while `ch_cnt` = 0.

## Configuration
- `PACKER_TLAST_FLUSH_EN` defined: an accepted beat with `TLAST` = 1 forces a row end, regardless of `input_channel_size`.
  - All its elements are taken (capped by the channel rule), the vector is zero-padded, `o_last` = 1, and both counters reset.
- `PACKER_TLAST_FLUSH_EN` undefined: `TLAST` is ignored.

## Structure
- The shared package `cnn_accel_pkg` holds:
  - `clog2`;
  - the state encoding `PACK_IDLE`, `PACK_FILL`, `PACK_HOLD`;
  - the default `ELEM_W` = 5.
- One sub-module, `vector_fwft_fifo` (`WIDTH`, `DEPTH`), stores `{o_last, o_data}`.
- Pack logic and the FSM live in the top module.

## Test plan
All scenarios use `DATA_W` = 32, `LANES` = 8, `ELEM_W` = 5, `DEPTH` = 4.
- Channel 8, beats 0x04030201, 0x08070605 → one vector, lanes 0..7 = 1..8, `o_last` = 1, latency 1 cycle after the second beat.
- Channel 6, same beats → lanes 1,2,3,4,5,6,0,0, `o_last` = 1; bytes 7 and 8 are dropped.
- Channel 0, `o_ready` = 0, 8 beats → `fifo_cnt` = 4, `fifo_full` = 1, `TREADY` = 0; one pop → `TREADY` = 1 the next cycle, `fifo_cnt` = 3.
- Beat 0xFF80FF1F, channel 4 → lanes 31,31,0,31,0,0,0,0.
- `PACKER_TLAST_FLUSH_EN` defined: channel 0, single beat 0x04030201 with `TLAST` → lanes 1,2,3,4,0,0,0,0, `o_last` = 1. Undefined: no output until a second beat.
- `axis_clear` after one beat of a partial vector, then beats 0x0D0C0B0A, 0x11100F0E (channel 8) → lanes 10..17; FIFO empty before the first of these beats.
